// File: rtl/hs_stream_sink.sv
// Consumer end of the 8-bit valid/ready stream: programmable backpressure,
// incrementing-sequence data checker, producer protocol monitor and counters.
module hs_stream_sink #(
  parameter int          DATA_W    = 8,
  parameter int          CNT_W     = 16,
  parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [1:0]        mode_i,
  input  logic [7:0]        thresh_i,
  input  logic              halt_on_err_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              ready_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [CNT_W-1:0]  err_cnt_o,
  output logic              seq_err_o,
  output logic              proto_err_o,
  output logic              halted_o
);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                halted_q;
  logic                seq_err_q, proto_err_q;
  logic                pend_q;
  logic [DATA_W-1:0]   exp_q, pdata_q;
  logic [7:0]          lfsr_q, lfsr_nxt;
  logic [CNT_W-1:0]    beat_q, err_q;

  logic                fire, in_run, seq_now, proto_now, pat;
  logic [1:0]          err_inc;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W+1)'(inc);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign fire      = valid_i & ready_q;
  assign in_run    = (state_q == RUN);
  assign seq_now   = fire & (data_i != exp_q);
  // A stalled beat must stay valid with unchanged data until it is taken.
  assign proto_now = in_run & pend_q & (~valid_i | (data_i != pdata_q));
  assign err_inc   = {1'b0, seq_now} + {1'b0, proto_now};
  assign lfsr_nxt  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    case (mode_i)
      2'b00:   pat = 1'b1;
      2'b01:   pat = 1'b0;
      2'b10:   pat = ~ready_q;
      default: pat = (lfsr_nxt < thresh_i);
    endcase
  end

  // Ready drops early when a halting error is seen, so no beat slips in
  // between the error pulse and the move to HALT.
  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      IDLE: if (en_i) state_d = RUN;
      RUN: begin
        if (!en_i)
          state_d = IDLE;
        else if (halt_on_err_i && (seq_err_q || proto_err_q))
          state_d = HALT;
        else if (!(halt_on_err_i && (seq_now || proto_now)))
          ready_d = pat;
      end
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      halted_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      pend_q      <= 1'b0;
      exp_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      beat_q      <= '0;
      err_q       <= '0;
    end else if (clr_i) begin
      state_q     <= IDLE;
      ready_q     <= 1'b0;
      halted_q    <= 1'b0;
      seq_err_q   <= 1'b0;
      proto_err_q <= 1'b0;
      pend_q      <= 1'b0;
      exp_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      beat_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      halted_q    <= (state_d == HALT);
      seq_err_q   <= seq_now;
      proto_err_q <= proto_now;
      pend_q      <= valid_i & ~ready_q & in_run;
      err_q       <= sat_add(err_q, err_inc);
      if (fire) begin
        beat_q <= sat_add(beat_q, 2'd1);
        exp_q  <= data_i + DATA_W'(1);
      end
      if (in_run && mode_i == 2'b11)
        lfsr_q <= lfsr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    pdata_q <= data_i;
  end

  assign ready_o     = ready_q;
  assign beat_cnt_o  = beat_q;
  assign err_cnt_o   = err_q;
  assign seq_err_o   = seq_err_q;
  assign proto_err_o = proto_err_q;
  assign halted_o    = halted_q;

endmodule

// File: tb/tb_hs_stream_sink.sv
// Directed bench for hs_stream_sink; a narrow-counter second instance shares
// the stimulus to exercise counter saturation.
module tb_hs_stream_sink;

  logic        clk = 1'b0;
  logic        rst_n, en, clr, halt, valid;
  logic [1:0]  mode;
  logic [7:0]  thresh, data;

  logic        ready_o, seq_err_o, proto_err_o, halted_o;
  logic [15:0] beat_cnt_o, err_cnt_o;
  logic        s_ready, s_seq, s_proto, s_halt;
  logic [2:0]  s_beat, s_err;

  int checks = 0;
  int passed = 0;
  int nseq = 0;
  int nproto = 0;
  int cyc = 0;
  int ones = 0;
  int lticks = 0;
  logic [7:0] lfsr_m;
  bit         run_m;
  logic [7:0] dval;

  always #5 clk = ~clk;

  hs_stream_sink #(.DATA_W(8), .CNT_W(16), .LFSR_SEED(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .thresh_i(thresh), .halt_on_err_i(halt), .valid_i(valid), .data_i(data),
    .ready_o(ready_o), .beat_cnt_o(beat_cnt_o), .err_cnt_o(err_cnt_o),
    .seq_err_o(seq_err_o), .proto_err_o(proto_err_o), .halted_o(halted_o)
  );

  hs_stream_sink #(.DATA_W(8), .CNT_W(3), .LFSR_SEED(8'hA5)) u_sat (
    .clk(clk), .rst_n(rst_n), .en_i(en), .clr_i(clr), .mode_i(mode),
    .thresh_i(thresh), .halt_on_err_i(halt), .valid_i(valid), .data_i(data),
    .ready_o(s_ready), .beat_cnt_o(s_beat), .err_cnt_o(s_err),
    .seq_err_o(s_seq), .proto_err_o(s_proto), .halted_o(s_halt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  function automatic logic [7:0] lnext(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (seq_err_o)   nseq++;
    if (proto_err_o) nproto++;
  endtask

  // Tick while predicting ready_o from an independent LFSR model.
  task automatic tick_l();
    tick();
    if (run_m) begin
      lfsr_m = lnext(lfsr_m);
      chk("lfsr_ready", 32'(ready_o), 32'(lfsr_m < thresh));
      lticks++;
      if (ready_o) ones++;
    end else begin
      chk("lfsr_first", 32'(ready_o), 32'd0);
      run_m = 1'b1;
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    valid = 1'b0;
    tick();
    clr = 1'b0;
    lfsr_m = 8'hA5;
    run_m = 1'b0;
    dval = 8'h00;
    nseq = 0;
    nproto = 0;
  endtask

  // Producer holding valid and advancing the incrementing data on each fire.
  task automatic stream(input int n, input bit lchk);
    int got = 0;
    int guard = 0;
    bit f;
    valid = 1'b1;
    data = dval;
    while (got < n && guard < 4000) begin
      f = ready_o;
      if (lchk) tick_l(); else tick();
      guard++;
      if (f) begin
        got++;
        dval = dval + 8'd1;
        data = dval;
      end
    end
    valid = 1'b0;
    chk("stream_done", 32'(got), 32'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int g;
    logic [7:0] seqv [5];
    seqv[0] = 8'h00; seqv[1] = 8'h01; seqv[2] = 8'h02; seqv[3] = 8'h05; seqv[4] = 8'h06;

    rst_n = 1'b0; en = 1'b0; clr = 1'b0; halt = 1'b0; valid = 1'b0;
    mode = 2'b00; thresh = 8'h80; data = 8'h00; dval = 8'h00;
    lfsr_m = 8'hA5; run_m = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd0);
    chk("rst_beat", 32'(beat_cnt_o), 32'd0);
    chk("rst_err", 32'(err_cnt_o), 32'd0);
    chk("rst_pulses", 32'({seq_err_o, proto_err_o, halted_o}), 32'd0);
    chk("rst_sat", 32'({s_ready, s_seq, s_proto, s_halt, s_beat, s_err}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Always-ready, 16 back-to-back beats
    en = 1'b1;
    tick();
    chk("t1_ready_c1", 32'(ready_o), 32'd0);
    tick();
    chk("t1_ready_c2", 32'(ready_o), 32'd1);
    stream(16, 1'b0);
    chk("t1_beat", 32'(beat_cnt_o), 32'd16);
    chk("t1_err", 32'(err_cnt_o), 32'd0);
    chk("t1_pulses", 32'(nseq + nproto), 32'd0);
    chk("t1_sat_beat", 32'(s_beat), 32'd7);

    // Toggle mode: fires on alternate cycles
    mode = 2'b10;
    do_clr();
    chk("t2_clr_beat", 32'(beat_cnt_o), 32'd0);
    chk("t2_clr_ready", 32'(ready_o), 32'd0);
    c0 = cyc;
    stream(8, 1'b0);
    chk("t2_cycles", 32'(cyc - c0), 32'd17);
    chk("t2_beat", 32'(beat_cnt_o), 32'd8);
    chk("t2_no_err", 32'(nseq + nproto), 32'd0);
    // Stall a correct beat, then swap in wrong data on the accepting cycle
    valid = 1'b1;
    data = 8'h08;
    chk("t2_tog_low", 32'(ready_o), 32'd0);
    tick();
    chk("t2_tog_high", 32'(ready_o), 32'd1);
    data = 8'h50;
    tick();
    valid = 1'b0;
    chk("t2_both_pulses", 32'({seq_err_o, proto_err_o}), 32'h3);
    chk("t2_err2", 32'(err_cnt_o), 32'd2);
    chk("t2_beat9", 32'(beat_cnt_o), 32'd9);
    chk("t2_sat_err2", 32'(s_err), 32'd2);
    tick();
    chk("t2_pulse_end", 32'({seq_err_o, proto_err_o}), 32'h0);

    // LFSR mode, wraps data through FF->00, then repeats after clear
    mode = 2'b11;
    thresh = 8'h80;
    do_clr();
    stream(200, 1'b1);
    chk("t3_beat200", 32'(beat_cnt_o), 32'd200);
    chk("t3_err0", 32'(err_cnt_o), 32'd0);
    stream(60, 1'b1);
    chk("t3_beat260", 32'(beat_cnt_o), 32'd260);
    chk("t3_wrap_err0", 32'(err_cnt_o), 32'd0);
    chk("t3_no_pulses", 32'(nseq + nproto), 32'd0);
    chk("t3_duty", 32'(ones * 100 >= lticks * 35 && ones * 100 <= lticks * 65), 32'd1);
    do_clr();
    stream(200, 1'b1);
    chk("t3_rerun_beat", 32'(beat_cnt_o), 32'd200);

    // Sequence 0,1,2,5,6
    mode = 2'b00;
    do_clr();
    tick();
    tick();
    chk("t4_ready", 32'(ready_o), 32'd1);
    for (int i = 0; i < 5; i++) begin
      valid = 1'b1;
      data = seqv[i];
      tick();
      if (i == 2) chk("t4_no_err_2", 32'(seq_err_o), 32'd0);
      if (i == 3) begin
        chk("t4_seq_pulse", 32'(seq_err_o), 32'd1);
        chk("t4_err1", 32'(err_cnt_o), 32'd1);
      end
      if (i == 4) chk("t4_no_err_6", 32'(seq_err_o), 32'd0);
    end
    valid = 1'b0;
    tick();
    chk("t4_beat5", 32'(beat_cnt_o), 32'd5);
    chk("t4_err_final", 32'(err_cnt_o), 32'd1);
    chk("t4_one_pulse", 32'(nseq), 32'd1);

    // Repeated 0x00: one good beat then nine sequence errors
    do_clr();
    tick();
    tick();
    valid = 1'b1;
    data = 8'h00;
    repeat (10) tick();
    valid = 1'b0;
    tick();
    chk("t4b_err9", 32'(err_cnt_o), 32'd9);
    chk("t4b_beat10", 32'(beat_cnt_o), 32'd10);
    chk("t4b_sat_err", 32'(s_err), 32'd7);
    chk("t4b_sat_beat", 32'(s_beat), 32'd7);

    // Never-ready: protocol violations, then HALT
    mode = 2'b01;
    halt = 1'b0;
    do_clr();
    tick();
    valid = 1'b1;
    data = 8'h33;
    tick();
    tick();
    chk("t5_hold_ok", 32'(proto_err_o), 32'd0);
    data = 8'h34;
    tick();
    chk("t5_proto", 32'(proto_err_o), 32'd1);
    chk("t5_err1", 32'(err_cnt_o), 32'd1);
    chk("t5_not_halted", 32'(halted_o), 32'd0);
    valid = 1'b0;
    tick();
    chk("t5_drop_err2", 32'(err_cnt_o), 32'd2);
    tick();
    chk("t5_quiet", 32'(proto_err_o), 32'd0);
    halt = 1'b1;
    valid = 1'b1;
    data = 8'h40;
    tick();
    data = 8'h41;
    tick();
    chk("t5_h_proto", 32'(proto_err_o), 32'd1);
    chk("t5_h_err3", 32'(err_cnt_o), 32'd3);
    chk("t5_h_pending", 32'(halted_o), 32'd0);
    tick();
    chk("t5_halted", 32'(halted_o), 32'd1);
    chk("t5_h_err_hold", 32'(err_cnt_o), 32'd3);
    valid = 1'b0;
    mode = 2'b00;
    tick();
    tick();
    chk("t5_halt_ready", 32'({halted_o, ready_o}), 32'h2);
    en = 1'b0;
    tick();
    chk("t5_halt_en0", 32'(halted_o), 32'd1);
    en = 1'b1;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_state", 32'({halted_o, ready_o}), 32'h0);
    chk("t5_clr_cnt", 32'({beat_cnt_o, err_cnt_o}), 32'h0);
    tick();
    chk("t5_idle_ready", 32'({halted_o, ready_o}), 32'h0);

    // Asynchronous reset in the middle of an LFSR burst
    mode = 2'b11;
    halt = 1'b0;
    do_clr();
    stream(20, 1'b1);
    chk("t6_beat20", 32'(beat_cnt_o), 32'd20);
    g = 0;
    while (ready_o !== 1'b1 && g < 50) begin
      tick_l();
      g++;
    end
    chk("t6_pre_ready", 32'(ready_o), 32'd1);
    valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(ready_o), 32'd0);
    chk("t6_rst_cnt", 32'({beat_cnt_o, err_cnt_o}), 32'h0);
    chk("t6_rst_flags", 32'({halted_o, seq_err_o, proto_err_o}), 32'h0);
    valid = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    lfsr_m = 8'hA5;
    run_m = 1'b0;
    dval = 8'h00;
    nseq = 0;
    nproto = 0;
    stream(10, 1'b1);
    chk("t6_post_beat", 32'(beat_cnt_o), 32'd10);
    chk("t6_no_pulses", 32'(nseq + nproto), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
